// File: rtl/return_address_stack.sv
// Call/return address stack: circular storage with saturating occupancy,
// sticky overflow/underflow flags and a pipeline-hold qualifier.
module return_address_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 12,
  parameter int unsigned CW    = 4
) (
  input  logic          clock,
  input  logic          init_signal_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          hold,
  input  logic          err_clear,
  output logic [AW-1:0] top_addr,
  output logic          top_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_top_ptr;
  logic          w_wr_en;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_set_ovf;
  logic          w_set_udf;

  assign w_push    = push & ~hold;
  assign w_pop     = pop & ~hold;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_top_ptr = r_wr_ptr - PW'(1);

  // Zero-latency top so the PC mux can capture it on the pop edge
  assign top_addr      = w_empty ? '0 : r_mem[w_top_ptr];
  assign top_valid     = ~w_empty;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = w_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_udf;

  // Next-state decode for pointer, occupancy, storage write and error events
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_wr_ptr;
    w_ptr_nxt   = r_wr_ptr;
    w_count_nxt = r_count;
    w_set_ovf   = 1'b0;
    w_set_udf   = 1'b0;
    if (w_push && w_pop) begin
      w_wr_en = 1'b1;
      if (w_empty) begin
        w_ptr_nxt   = r_wr_ptr + PW'(1);
        w_count_nxt = r_count + CW'(1);
        w_set_udf   = 1'b1;
      end else begin
        // Return followed by call: replace the consumed top in place
        w_wr_idx = w_top_ptr;
      end
    end else if (w_push) begin
      w_wr_en   = 1'b1;
      w_ptr_nxt = r_wr_ptr + PW'(1);
      if (w_full) begin
        w_set_ovf = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end else if (w_pop) begin
      if (w_empty) begin
        w_set_udf = 1'b1;
      end else begin
        w_ptr_nxt   = w_top_ptr;
        w_count_nxt = r_count - CW'(1);
      end
    end
  end

  // Control state; storage contents are deliberately left out of reset
  always_ff @(posedge clock or negedge init_signal_n) begin
    if (!init_signal_n) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_ptr_nxt;
      r_count  <= w_count_nxt;
      if (w_set_ovf)      r_ovf <= 1'b1;
      else if (err_clear) r_ovf <= 1'b0;
      if (w_set_udf)      r_udf <= 1'b1;
      else if (err_clear) r_udf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[w_wr_idx] <= push_addr;
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_return_address_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 12;
  localparam int unsigned CW    = 4;

  logic          clk;
  logic          rst_n;
  logic          i_push;
  logic          i_pop;
  logic [AW-1:0] i_addr;
  logic          i_hold;
  logic          i_clr;
  logic [AW-1:0] top_addr;
  logic          top_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          udf;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] m_q [$];
  logic          m_ovf;
  logic          m_udf;
  logic [AW-1:0] pre_top;

  typedef struct {
    logic          push;
    logic          pop;
    logic          hold;
    logic          clr;
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_pre_top;
    logic [CW-1:0] exp_cnt;
    logic [AW-1:0] exp_top;
    logic          exp_ovf;
    logic          exp_udf;
  } vec_t;

  vec_t tbl [11];

  return_address_stack #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clock        (clk),
    .init_signal_n(rst_n),
    .push         (i_push),
    .pop          (i_pop),
    .push_addr    (i_addr),
    .hold         (i_hold),
    .err_clear    (i_clr),
    .top_addr     (top_addr),
    .top_valid    (top_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_err (ovf),
    .underflow_err(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] m_top();
    return (m_q.size() > 0) ? m_q[$] : '0;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endfunction

  // Stack semantics stated directly: newest at the back, oldest dropped when full
  function automatic void m_apply(input logic p, input logic q, input logic h,
                                  input logic c, input logic [AW-1:0] a);
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (!h) begin
      if (p && q) begin
        if (m_q.size() == 0) begin
          m_q.push_back(a);
          su = 1'b1;
        end else begin
          m_q[m_q.size()-1] = a;
        end
      end else if (p) begin
        if (m_q.size() == DEPTH) begin
          void'(m_q.pop_front());
          so = 1'b1;
        end
        m_q.push_back(a);
      end else if (q) begin
        if (m_q.size() == 0) su = 1'b1;
        else void'(m_q.pop_back());
      end
    end
    m_ovf = so ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_udf = su ? 1'b1 : (c ? 1'b0 : m_udf);
  endfunction

  task automatic check_model();
    chk("count",     32'(count),     32'(m_q.size()));
    chk("top_addr",  32'(top_addr),  32'(m_top()));
    chk("top_valid", 32'(top_valid), 32'(m_q.size() > 0));
    chk("full",      32'(full),      32'(m_q.size() == DEPTH));
    chk("empty",     32'(empty),     32'(m_q.size() == 0));
    chk("overflow",  32'(ovf),       32'(m_ovf));
    chk("underflow", 32'(udf),       32'(m_udf));
  endtask

  // One clock: drive, check pre-edge top, clock, update model, check
  task automatic step(input logic p, input logic q, input logic h,
                      input logic c, input logic [AW-1:0] a);
    i_push = p; i_pop = q; i_hold = h; i_clr = c; i_addr = a;
    #1;
    pre_top = top_addr;
    chk("pre_top", 32'(pre_top), 32'(m_top()));
    @(posedge clk);
    #1;
    m_apply(p, q, h, c, a);
    check_model();
    i_push = 1'b0; i_pop = 1'b0; i_hold = 1'b0; i_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_push = 1'b0; i_pop = 1'b0; i_hold = 1'b0; i_clr = 1'b0; i_addr = '0;
    m_reset();

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 12'h000, 4'd1, 12'h010, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 12'h010, 4'd2, 12'h020, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h030, 12'h020, 4'd3, 12'h030, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h030, 4'd2, 12'h020, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h020, 4'd1, 12'h010, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h010, 4'd0, 12'h000, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h100, 12'h000, 4'd1, 12'h100, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h200, 12'h100, 4'd2, 12'h200, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 12'h2AA, 12'h200, 4'd2, 12'h2AA, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h2AA, 4'd1, 12'h100, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h100, 4'd0, 12'h000, 1'b0, 1'b0};

    #3;
    check_model();
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].hold, tbl[i].clr, tbl[i].addr);
      chk("tbl_pre_top", 32'(pre_top),  32'(tbl[i].exp_pre_top));
      chk("tbl_count",   32'(count),    32'(tbl[i].exp_cnt));
      chk("tbl_top",     32'(top_addr), 32'(tbl[i].exp_top));
      chk("tbl_ovf",     32'(ovf),      32'(tbl[i].exp_ovf));
      chk("tbl_udf",     32'(udf),      32'(tbl[i].exp_udf));
    end

    // Overflow: nine pushes into eight entries, then drain
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, AW'(i));
    chk("ovf_full",  32'(full),     32'd1);
    chk("ovf_count", 32'(count),    32'd8);
    chk("ovf_flag",  32'(ovf),      32'd1);
    chk("ovf_top",   32'(top_addr), 32'h009);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, '0);
      chk("drain_pre_top", 32'(pre_top), 32'(9 - i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Underflow with set-wins-over-clear
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("udf_set",   32'(udf),      32'd1);
    chk("udf_top",   32'(top_addr), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("udf_set_wins", 32'(udf), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("udf_clear", 32'(udf), 32'd0);

    // Hold freezes push/pop
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h0A1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 12'h555);
    chk("hold_count", 32'(count),    32'd1);
    chk("hold_top",   32'(top_addr), 32'h0A1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h555);
    chk("rel_count", 32'(count),    32'd2);
    chk("rel_top",   32'(top_addr), 32'h555);

    // Asynchronous reset between edges
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h0AB);
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h0CD);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_count", 32'(count),    32'd0);
    chk("arst_empty", 32'(empty),    32'd1);
    chk("arst_top",   32'(top_addr), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 12'h0EF);
    chk("post_rst_top",   32'(top_addr), 32'h0EF);
    chk("post_rst_count", 32'(count),    32'd1);

    // Random traffic: push-biased phase, then pop-biased phase
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic p, q, h, c;
      r = $urandom_range(0, 99);
      if (i < 300) begin
        p = (r < 60); q = (r >= 45 && r < 80);
      end else begin
        p = (r < 30); q = (r >= 20 && r < 85);
      end
      h = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 19) == 0);
      step(p, q, h, c, AW'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
